mem_wb_stage: RTL and testbench

Memory-access and writeback stage of the 3-stage RISC-V pipeline. It sits directly downstream of the execute ALU and consumes its 32-bit result and 6-bit alu_control. ALU results go straight to the register-file write port. Load/store words (ALU_L_WORD / ALU_S_WORD) are run over a req/ack data-memory handshake, with pipeline stall and a bus timeout.

---
 rtl/mem_wb_stage_pkg.sv | 19 +
 rtl/mem_wb_stage_fsm.sv | 124 ++++++++++++
 rtl/mem_wb_stage.sv | 94 +++++++++
 tb/tb_mem_wb_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared opcodes, state encodings and defaults for the MEM/WB stage.
// Optional misaligned-access trap: define MEM_MISALIGN_CHECK_EN.
package mem_wb_stage_pkg;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_SUB    = 6'd1;
  localparam logic [5:0] ALU_L_WORD = 6'd20;
  localparam logic [5:0] ALU_S_WORD = 6'd21;

  localparam logic [0:0] MWB_IDLE   = 1'b0;
  localparam logic [0:0] MWB_ACCESS = 1'b1;

  localparam int ACK_TIMEOUT_DEF = 16;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == ALU_L_WORD) || (op == ALU_S_WORD);
  endfunction

endpackage

// File: rtl/mem_wb_stage_fsm.sv
// Data-memory request FSM: IDLE/ACCESS, ack timeout, dmem_* registers and stall.
// With MEM_MISALIGN_CHECK_EN defined, misaligned loads/stores trap instead of issuing.
module mem_req_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int CNT_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            is_mem,
  input  logic            is_store,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  input  logic            dmem_ack,
  output logic            idle,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            bus_err,
  output logic            ld_ack,
  output logic [4:0]      ld_rd,
  output logic            ld_rw
);

  logic [0:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d, err_q, err_d, rw_q, rw_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            misalign, timeout, issue;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = alu_result[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif

  assign timeout = cnt_q == CNT_W'(ACK_TIMEOUT - 1);
  assign issue   = (state_q == MWB_IDLE) && in_valid && is_mem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    err_d   = 1'b0;
    case (state_q)
      MWB_IDLE: begin
        if (issue && misalign) begin
          err_d = 1'b1;
        end else if (issue) begin
          state_d = MWB_ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = alu_result;
          wdata_d = store_data;
          rd_d    = rd_addr;
          rw_d    = reg_write;
        end
      end
      default: begin
        // ack takes priority over a simultaneous timeout
        if (dmem_ack) begin
          state_d = MWB_IDLE;
          req_d   = 1'b0;
        end else if (timeout) begin
          state_d = MWB_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MWB_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end

  assign idle       = state_q == MWB_IDLE;
  assign stall      = !rst && (idle ? (issue && !misalign) : (!dmem_ack && !timeout));
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign bus_err    = err_q;
  assign ld_ack     = !idle && dmem_ack && !we_q;
  assign ld_rd      = rd_q;
  assign ld_rw      = rw_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage top: ALU results and load data into the register-file write port.
// Optional misaligned-access trap: define MEM_MISALIGN_CHECK_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int CNT_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [5:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            bus_err
);

  logic            is_mem, idle, ld_ack, ld_rw;
  logic [4:0]      ld_rd;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  assign is_mem = is_mem_op(alu_control);

  mem_req_fsm #(.XLEN(XLEN), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .is_mem     (is_mem),
    .is_store   (alu_control == ALU_S_WORD),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_addr    (rd_addr),
    .reg_write  (reg_write),
    .dmem_ack   (dmem_ack),
    .idle       (idle),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .bus_err    (bus_err),
    .ld_ack     (ld_ack),
    .ld_rd      (ld_rd),
    .ld_rw      (ld_rw)
  );

  // x0 is never written; address/data hold when nothing retires
  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (idle && in_valid && !is_mem) begin
      wb_en_d   = reg_write && (rd_addr != 5'd0);
      wb_addr_d = rd_addr;
      wb_data_d = alu_result;
    end else if (ld_ack) begin
      wb_en_d   = ld_rw && (ld_rd != 5'd0);
      wb_addr_d = ld_rd;
      wb_data_d = dmem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; inputs change on negedge,
// outputs are sampled on negedge (or #1 after an input change for comb paths).
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  alu_control = ALU_ADD;
  logic [31:0] alu_result = '0, store_data = '0, dmem_rdata = '0;
  logic [4:0]  rd_addr = '0;
  logic        reg_write = 1'b0, dmem_ack = 1'b0;
  logic        stall, dmem_req, dmem_we, wb_en, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_addr;

  int n_cmp = 0, n_bad = 0;
  int req_cnt;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_control(alu_control),
    .alu_result(alu_result), .store_data(store_data), .rd_addr(rd_addr),
    .reg_write(reg_write), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] res,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rw);
    in_valid = v; alu_control = op; alu_result = res; store_data = sd;
    rd_addr = rd; reg_write = rw;
  endtask

  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_addr", dmem_addr, 0);
    @(negedge clk); rst = 1'b0;

    // ALU op writes back next cycle
    drive(1, ALU_ADD, 32'h5, 0, 5'd3, 1); #1;
    chk("add_stall", stall, 0);
    @(negedge clk);
    chk("add_wb_en", wb_en, 1);
    chk("add_wb_addr", wb_addr, 3);
    chk("add_wb_data", wb_data, 5);
    drive(0, ALU_ADD, 32'h99, 0, 5'd4, 1);
    @(negedge clk);
    chk("idle_wb_en", wb_en, 0);
    chk("idle_wb_hold", wb_data, 5);

    // load, ack in third ACCESS cycle
    drive(1, ALU_L_WORD, 32'h100, 0, 5'd7, 1); #1;
    chk("ld_stall0", stall, 1);
    chk("ld_req0", dmem_req, 0);
    @(negedge clk);
    chk("ld_req1", dmem_req, 1);
    chk("ld_stall1", stall, 1);
    chk("ld_addr1", dmem_addr, 32'h100);
    chk("ld_we", dmem_we, 0);
    chk("ld_wb_en1", wb_en, 0);
    @(negedge clk);
    chk("ld_req2", dmem_req, 1);
    chk("ld_stall2", stall, 1);
    @(negedge clk);
    chk("ld_addr3", dmem_addr, 32'h100);
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
    chk("ld_stall_ack", stall, 0);
    chk("ld_req3", dmem_req, 1);
    @(negedge clk);
    dmem_ack = 0; drive(0, ALU_ADD, 0, 0, 0, 0);
    chk("ld_wb_en", wb_en, 1);
    chk("ld_wb_addr", wb_addr, 7);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_req_done", dmem_req, 0);
    @(negedge clk);
    chk("ld_wb_pulse", wb_en, 0);

    // store, ack in first ACCESS cycle
    drive(1, ALU_S_WORD, 32'h20, 32'h1234, 5'd9, 0);
    @(negedge clk);
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h20);
    chk("st_wdata", dmem_wdata, 32'h1234);
    dmem_ack = 1; #1;
    chk("st_stall_ack", stall, 0);
    @(negedge clk);
    dmem_ack = 0; drive(0, ALU_ADD, 0, 0, 0, 0);
    chk("st_wb_en", wb_en, 0);
    chk("st_req_done", dmem_req, 0);

    // load with no ack: timeout after 16 request cycles
    drive(1, ALU_L_WORD, 32'h40, 0, 5'd5, 1);
    req_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dmem_req) req_cnt++;
      if (i == 15) begin
        chk("to_stall_last", stall, 0);
        drive(0, ALU_ADD, 0, 0, 0, 0);
      end
    end
    chk("to_req_cycles", req_cnt, 16);
    @(negedge clk);
    chk("to_req_off", dmem_req, 0);
    chk("to_bus_err", bus_err, 1);
    chk("to_wb_en", wb_en, 0);
    @(negedge clk);
    chk("to_bus_err_pulse", bus_err, 0);

    // ack on the timeout cycle wins
    drive(1, ALU_L_WORD, 32'h44, 0, 5'd6, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin dmem_ack = 1; dmem_rdata = 32'hCAFE0001; end
    end
    @(negedge clk);
    dmem_ack = 0; drive(0, ALU_ADD, 0, 0, 0, 0);
    chk("ackto_bus_err", bus_err, 0);
    chk("ackto_wb_en", wb_en, 1);
    chk("ackto_wb_data", wb_data, 32'hCAFE0001);
    chk("ackto_wb_addr", wb_addr, 6);

    // load to x0
    drive(1, ALU_L_WORD, 32'h48, 0, 5'd0, 1);
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'h11111111;
    @(negedge clk);
    dmem_ack = 0; drive(0, ALU_ADD, 0, 0, 0, 0);
    chk("x0_wb_en", wb_en, 0);

    // ALU op without reg_write
    drive(1, ALU_SUB, 32'h77, 0, 5'd4, 0);
    @(negedge clk);
    drive(0, ALU_ADD, 0, 0, 0, 0);
    chk("norw_wb_en", wb_en, 0);

    // misaligned load
    drive(1, ALU_L_WORD, 32'h103, 0, 5'd8, 1); #1;
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_stall", stall, 0);
    @(negedge clk);
    drive(0, ALU_ADD, 0, 0, 0, 0);
    chk("mis_req", dmem_req, 0);
    chk("mis_bus_err", bus_err, 1);
    chk("mis_wb_en", wb_en, 0);
`else
    chk("mis_stall", stall, 1);
    @(negedge clk);
    chk("mis_addr", dmem_addr, 32'h103);
    dmem_ack = 1; dmem_rdata = 32'h0;
    @(negedge clk);
    dmem_ack = 0; drive(0, ALU_ADD, 0, 0, 0, 0);
`endif
    @(negedge clk);

    // async reset mid-ACCESS
    drive(1, ALU_L_WORD, 32'h200, 0, 5'd10, 1);
    @(negedge clk);
    chk("rstm_req_before", dmem_req, 1);
    #2 rst = 1; #1;
    chk("rstm_req", dmem_req, 0);
    chk("rstm_stall", stall, 0);
    chk("rstm_wb_en", wb_en, 0);
    drive(0, ALU_ADD, 0, 0, 0, 0);
    @(negedge clk); rst = 0;
    drive(1, ALU_ADD, 32'h77, 0, 5'd2, 1);
    @(negedge clk);
    drive(0, ALU_ADD, 0, 0, 0, 0);
    chk("rstm_after_en", wb_en, 1);
    chk("rstm_after_addr", wb_addr, 2);
    chk("rstm_after_data", wb_data, 32'h77);
    chk("rstm_after_req", dmem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
